// File: rtl/alu_pkg.sv
// Shared operation codes, widths and a bit-reverse helper for the alu32 datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  localparam logic [3:0] FN_ADD  = 4'd0;
  localparam logic [3:0] FN_SUB  = 4'd1;
  localparam logic [3:0] FN_AND  = 4'd2;
  localparam logic [3:0] FN_OR   = 4'd3;
  localparam logic [3:0] FN_XOR  = 4'd4;
  localparam logic [3:0] FN_NOR  = 4'd5;
  localparam logic [3:0] FN_NOT  = 4'd6;
  localparam logic [3:0] FN_SLL  = 4'd7;
  localparam logic [3:0] FN_SRL  = 4'd8;
  localparam logic [3:0] FN_SRA  = 4'd9;
  localparam logic [3:0] FN_SLLV = 4'd10;
  localparam logic [3:0] FN_SRLV = 4'd11;
  localparam logic [3:0] FN_SRAV = 4'd12;
  localparam logic [3:0] FN_SLT  = 4'd13;
  localparam logic [3:0] FN_SLTU = 4'd14;
  localparam logic [3:0] FN_LUI  = 4'd15;

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_W; i++) r[i] = d[DATA_W-1-i];
    return r;
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// 5-stage combinational barrel shifter; left shifts reuse the right-shift network via bit reversal.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0]  data,
  input  logic [SHAMT_W-1:0] amt,
  input  logic               dir,    // 1 = left, 0 = right
  input  logic               arith,  // sign fill on right shifts
  output logic [DATA_W-1:0]  q
);

  logic [SHAMT_W:0][DATA_W-1:0] stg;
  logic                         fill;

  assign fill   = arith & ~dir & data[DATA_W-1];
  assign stg[0] = dir ? bit_rev(data) : data;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    assign stg[k+1] = amt[k] ? {{(1 << k){fill}}, stg[k][DATA_W-1:(1 << k)]} : stg[k];
  end

  assign q = dir ? bit_rev(stg[SHAMT_W]) : stg[SHAMT_W];

endmodule

// File: rtl/alu32.sv
// 32-bit ALU: op mux on funct feeding a single result register with synchronous reset.
// Latency: 1 cycle from inputs to res; res holds while inputs are held.
// Backpressure: none; a new result is captured on every clock edge.
module alu32
  import alu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    a,
  input  logic [DATA_W-1:0]    b,
  input  logic [SHAMT_W-1:0]   shamt,
  input  logic [3:0]           funct,
  output logic [DATA_W-1:0]    res
);

  logic [SHAMT_W-1:0] sh_amt;
  logic               sh_left;
  logic               sh_arith;
  logic [DATA_W-1:0]  sh_q;
  logic [DATA_W-1:0]  res_nxt;

  // Variable shifts take the amount from b[4:0]; immediate shifts from shamt.
  always_comb begin
    sh_amt   = shamt;
    sh_left  = 1'b0;
    sh_arith = 1'b0;
    if (funct == FN_SLLV || funct == FN_SRLV || funct == FN_SRAV) sh_amt = b[SHAMT_W-1:0];
    if (funct == FN_SLL  || funct == FN_SLLV) sh_left  = 1'b1;
    if (funct == FN_SRA  || funct == FN_SRAV) sh_arith = 1'b1;
  end

  alu_shifter u_shifter (
    .data  (a),
    .amt   (sh_amt),
    .dir   (sh_left),
    .arith (sh_arith),
    .q     (sh_q)
  );

  always_comb begin
    res_nxt = '0;
    case (funct)
      FN_ADD:  res_nxt = a + b;
      FN_SUB:  res_nxt = a - b;
      FN_AND:  res_nxt = a & b;
      FN_OR:   res_nxt = a | b;
      FN_XOR:  res_nxt = a ^ b;
      FN_NOR:  res_nxt = ~(a | b);
      FN_NOT:  res_nxt = ~a;
      FN_SLL, FN_SRL, FN_SRA,
      FN_SLLV, FN_SRLV, FN_SRAV:
               res_nxt = sh_q;
      FN_SLT:  res_nxt = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      FN_SLTU: res_nxt = {{(DATA_W-1){1'b0}}, (a < b)};
      FN_LUI:  res_nxt = {b[15:0], 16'h0000};
      default: res_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) res <= '0;
    else     res <= res_nxt;
  end

endmodule

// File: tb/tb_alu32.sv
// Randomized and directed self-checking bench for alu32 against an arithmetic reference model.
module tb_alu32;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic [4:0]  shamt;
  logic [3:0]  funct;
  logic [31:0] res;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu32 dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .shamt (shamt),
    .funct (funct),
    .res   (res)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic [4:0] s, input logic [3:0] f);
    logic signed [31:0] sx;
    int                 vs;
    sx = x;
    vs = int'(y % 32);
    case (f)
      0:  return x + y;
      1:  return x - y;
      2:  return x & y;
      3:  return x | y;
      4:  return x ^ y;
      5:  return ~(x | y);
      6:  return ~x;
      7:  return x << s;
      8:  return x >> s;
      9:  return sx >>> s;
      10: return x << vs;
      11: return x >> vs;
      12: return sx >>> vs;
      13: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      14: return (x < y) ? 32'd1 : 32'd0;
      default: return y * 32'h10000;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] f, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] s);
    funct = f; a = x; b = y; shamt = s;
  endtask

  task automatic op_chk(input string tag, input logic [3:0] f, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] s, input logic [31:0] exp);
    drive(f, x, y, s);
    step();
    chk(tag, res, exp);
  endtask

  initial begin
    logic [31:0] held;
    rst = 1'b1;
    drive(FN_ADD, 32'd5, 32'd7, 5'd0);
    step();
    chk("reset", res, 32'd0);
    rst = 1'b0;
    step();
    chk("add_after_reset", res, 32'd12);

    op_chk("add_wrap",  FN_ADD, 32'h7FFFFFFF, 32'd1, 5'd0, 32'h80000000);
    op_chk("sub_wrap",  FN_SUB, 32'd0, 32'd1, 5'd0, 32'hFFFFFFFF);
    op_chk("sub_neg",   FN_SUB, -32'sd3, 32'd4, 5'd0, -32'sd7);
    op_chk("and",  FN_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'h00F000F0);
    op_chk("or",   FN_OR,  32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'hFFF0FFF0);
    op_chk("xor",  FN_XOR, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'hFF00FF00);
    op_chk("nor",  FN_NOR, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'h000F000F);
    op_chk("not",  FN_NOT, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'h0F0F0F0F);
    op_chk("sll4", FN_SLL, 32'h80000001, 32'd0, 5'd4, 32'h00000010);
    op_chk("srl4", FN_SRL, 32'h80000001, 32'd0, 5'd4, 32'h08000000);
    op_chk("sra4", FN_SRA, 32'h80000001, 32'd0, 5'd4, 32'hF8000000);
    op_chk("srav31_neg", FN_SRAV, 32'h80000000, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFF);
    op_chk("sra31_pos",  FN_SRA,  32'h7FFFFFFF, 32'd0, 5'd31, 32'h00000000);
    op_chk("sll0", FN_SLL, 32'hDEADBEEF, 32'd0, 5'd0, 32'hDEADBEEF);
    op_chk("sra0", FN_SRA, 32'hDEADBEEF, 32'd0, 5'd0, 32'hDEADBEEF);
    op_chk("sllv_hi_ignored", FN_SLLV, 32'h00000001, 32'hFFFFFFE3, 5'd0, 32'h00000008);
    op_chk("srlv", FN_SRLV, 32'h80000000, 32'h00000021, 5'd7, 32'h40000000);
    op_chk("slt_neg",  FN_SLT,  32'h80000000, 32'd1, 5'd0, 32'd1);
    op_chk("sltu_neg", FN_SLTU, 32'h80000000, 32'd1, 5'd0, 32'd0);
    op_chk("slt_eq",   FN_SLT,  32'd5, 32'd5, 5'd0, 32'd0);
    op_chk("lui",      FN_LUI,  32'hFFFFFFFF, 32'h00001234, 5'd0, 32'h12340000);

    // Hold: fixed inputs give a constant result; a funct change lands exactly one edge later.
    drive(FN_XOR, 32'h12345678, 32'h0F0F0F0F, 5'd3);
    held = 32'h12345678 ^ 32'h0F0F0F0F;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold", res, held);
    end
    funct = FN_ADD;
    #2;
    chk("no_early_update", res, held);
    step();
    chk("update_one_edge", res, 32'h12345678 + 32'h0F0F0F0F);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 8 == 0) ra = 32'h80000000 >> $urandom_range(0, 31);
      if (i % 11 == 0) rb = ra;
      drive(4'($urandom_range(0, 15)), ra, rb, 5'($urandom_range(0, 31)));
      held = model(a, b, shamt, funct);
      step();
      chk($sformatf("rand_fn%0d", funct), res, held);
    end

    rst = 1'b1;
    drive(FN_NOT, 32'd0, 32'd0, 5'd0);
    step();
    chk("reset_priority", res, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
